// File: rtl/fft_scheduler.sv
// fft_scheduler: input buffer and two-pass sequencer around an external
// radix-4 butterfly. It gathers a 16-sample frame, feeds the butterfly the
// stage-1 words, and collects the results. It then feeds the transposed
// stage-2 words and streams the four stage-2 results out as the frame result.
// Words pass through bit-exact; the butterfly does all the arithmetic.
module fft_scheduler #(
   parameter int BF_LAT = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_in_valid,
   output logic         o_in_ready,
   input  logic [33:0]  i_in_data,
   output logic [135:0] o_calc_in,
   output logic [2:0]   o_rotation,
   input  logic [135:0] i_calc_out,
   output logic         o_out_valid,
   output logic [1:0]   o_out_idx,
   output logic [135:0] o_out_data,
   output logic         o_busy
);

   typedef enum logic [2:0] {
      S_LOAD   = 3'd0,
      S_ISSUE1 = 3'd1,
      S_WAIT1  = 3'd2,
      S_ISSUE2 = 3'd3,
      S_WAIT2  = 3'd4
   } state_t;

   state_t         r_state;
   state_t         w_state_next;
   logic [3:0]     r_cnt;
   logic [1:0]     r_g;
   logic [1:0]     w_g1;
   logic [33:0]    r_x [16];
   logic [33:0]    r_y [4][4];
   logic [135:0]   r_calc_in;
   logic [135:0]   w_calc_next;
   logic [2:0]     r_rotation;
   logic [2:0]     w_rot_next;
   // Tag layout: {valid, stage2, idx[1:0]}; entry 0 travels with o_calc_in.
   logic [3:0]     r_tag [BF_LAT+1];
   logic [3:0]     w_tag_next;
   logic           w_accept;
   logic           w_cap_valid;
   logic           w_cap_stage2;
   logic [1:0]     w_cap_idx;
   logic           w_cap1_last;
   logic           w_cap2_last;
   logic [33:0]    w_res [4];
   logic           r_out_valid;
   logic [1:0]     r_out_idx;
   logic [135:0]   r_out_data;
   logic           r_busy;

   // Split the butterfly result into its four complex slots (slot 0 at the MSBs).
   for (genvar gi = 0; gi < 4; gi++) begin : g_res
      assign w_res[gi] = i_calc_out[135-34*gi -: 34];
   end

   assign w_g1         = r_g + 2'd1;
   assign w_accept     = i_in_valid && (r_state == S_LOAD);
   assign w_cap_valid  = r_tag[BF_LAT][3];
   assign w_cap_stage2 = r_tag[BF_LAT][2];
   assign w_cap_idx    = r_tag[BF_LAT][1:0];
   assign w_cap1_last  = w_cap_valid && !w_cap_stage2 && (w_cap_idx == 2'd3);
   assign w_cap2_last  = w_cap_valid &&  w_cap_stage2 && (w_cap_idx == 2'd3);

   assign o_in_ready  = (r_state == S_LOAD);
   assign o_calc_in   = r_calc_in;
   assign o_rotation  = r_rotation;
   assign o_out_valid = r_out_valid;
   assign o_out_idx   = r_out_idx;
   assign o_out_data  = r_out_data;
   assign o_busy      = r_busy;

   // Next state and the word to present to the butterfly next cycle (zero when idle).
   always_comb begin
      w_state_next = r_state;
      w_calc_next  = '0;
      w_rot_next   = 3'd0;
      w_tag_next   = 4'd0;
      case (r_state)
         S_LOAD: begin
            if (w_accept && (r_cnt == 4'd15)) begin
               w_state_next = S_ISSUE1;
               w_calc_next  = {r_x[0], r_x[4], r_x[8], r_x[12]};
               w_rot_next   = 3'd0;
               w_tag_next   = 4'b1000;
            end
         end
         S_ISSUE1: begin
            if (r_g == 2'd3) begin
               w_state_next = S_WAIT1;
            end else begin
               w_calc_next = {r_x[{2'd0, w_g1}], r_x[{2'd1, w_g1}],
                              r_x[{2'd2, w_g1}], r_x[{2'd3, w_g1}]};
               w_rot_next  = {1'b0, w_g1};
               w_tag_next  = {2'b10, w_g1};
            end
         end
         S_WAIT1: begin
            // y[3] lands on this same edge, so its slot 0 comes straight off the bus.
            if (w_cap1_last) begin
               w_state_next = S_ISSUE2;
               w_calc_next  = {r_y[0][0], r_y[1][0], r_y[2][0], w_res[0]};
               w_rot_next   = 3'd4;
               w_tag_next   = 4'b1100;
            end
         end
         S_ISSUE2: begin
            if (r_g == 2'd3) begin
               w_state_next = S_WAIT2;
            end else begin
               w_calc_next = {r_y[0][w_g1], r_y[1][w_g1], r_y[2][w_g1], r_y[3][w_g1]};
               w_rot_next  = {1'b1, w_g1};
               w_tag_next  = {2'b11, w_g1};
            end
         end
         S_WAIT2: begin
            if (w_cap2_last) begin
               w_state_next = S_LOAD;
            end
         end
         default: w_state_next = S_LOAD;
      endcase
   end

   // State register, sample counter and issue-phase counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_LOAD;
         r_cnt   <= 4'd0;
         r_g     <= 2'd0;
      end else begin
         r_state <= w_state_next;
         if (w_accept) begin
            r_cnt <= r_cnt + 4'd1;
         end
         if ((r_state == S_ISSUE1) || (r_state == S_ISSUE2)) begin
            r_g <= r_g + 2'd1;
         end else begin
            r_g <= 2'd0;
         end
      end
   end

   // Input sample store; contents are meaningless until a frame is loaded.
   always_ff @(posedge clk) begin
      if (rst_n && w_accept) begin
         r_x[r_cnt] <= i_in_data;
      end
   end

   // Butterfly drive registers and the latency tag pipe that follows them.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_calc_in  <= '0;
         r_rotation <= 3'd0;
         for (int i = 0; i <= BF_LAT; i++) begin
            r_tag[i] <= 4'd0;
         end
      end else begin
         r_calc_in  <= w_calc_next;
         r_rotation <= w_rot_next;
         r_tag[0]   <= w_tag_next;
         for (int i = BF_LAT; i > 0; i--) begin
            r_tag[i] <= r_tag[i-1];
         end
      end
   end

   // Stage-1 result capture into the transpose buffer.
   always_ff @(posedge clk) begin
      if (rst_n && w_cap_valid && !w_cap_stage2) begin
         for (int j = 0; j < 4; j++) begin
            r_y[w_cap_idx][j] <= w_res[j];
         end
      end
   end

   // Stage-2 results go straight to the output register; busy spans the frame.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_idx   <= 2'd0;
         r_out_data  <= '0;
         r_busy      <= 1'b0;
      end else begin
         r_out_valid <= w_cap_valid && w_cap_stage2;
         if (w_cap_valid && w_cap_stage2) begin
            r_out_idx  <= w_cap_idx;
            r_out_data <= i_calc_out;
         end
         if (w_accept) begin
            r_busy <= 1'b1;
         end else if (r_out_valid && (r_out_idx == 2'd3)) begin
            r_busy <= 1'b0;
         end
      end
   end

endmodule
